store_buffer: RTL and testbench
===============================

Name: store_buffer

Overview:
- Word-granular store buffer between the MEM stage and data memory, DEPTH entries, drained in FIFO order.
- Accepts SW commits from the MEM stage and retires them to data memory through a req/ack handshake.
- Answers MEM-stage LW lookups combinationally, forwarding the youngest pending store to the same word.
- Lets a load that follows a store read the stored value without waiting for the memory write.

Parameters:
- DEPTH, 4, number of entries; power of two, at least 2.
- ADDR_W, 32, byte address width; word match uses bits [ADDR_W-1:2].
- DATA_W, 32, store/load data width.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- st_valid  input  1  MEM stage commits a store this cycle.
- st_addr  input  ADDR_W  store byte address.
- st_data  input  DATA_W  store data.
- st_ready  output  1  buffer can accept a store this cycle (= !full).
- ld_valid  input  1  MEM stage performs a load this cycle.
- ld_addr  input  ADDR_W  load byte address.
- ld_hit  output  1  load matches a pending or same-cycle store.
- ld_data  output  DATA_W  forwarded data; valid when ld_hit=1.
- mem_wr_req  output  1  head entry presented to data memory.
- mem_wr_addr  output  ADDR_W  head entry address.
- mem_wr_data  output  DATA_W  head entry data.
- mem_wr_ack  input  1  memory accepted the head entry this cycle.
- full  output  1  count == DEPTH.
- empty  output  1  count == 0.
- count  output  $clog2(DEPTH+1)  number of occupied entries.

Behaviour:
- Storage: circular array of {valid, addr, data}; head pointer, tail pointer, count register.
- Reset (async, rst_n=0): head=0, tail=0, count=0, all valid bits cleared.
  - Output values under reset: st_ready=1, empty=1, full=0, mem_wr_req=0, ld_hit=0, ld_data=0, mem_wr_addr=0, mem_wr_data=0.
- Reset mid-operation discards all pending stores; there is no drain on reset.
- Enqueue: a store is accepted when st_valid && st_ready.
  - The entry is written at tail on the rising edge; tail increments modulo DEPTH; the valid bit is set.
  - st_valid while full: the store is not accepted, no state changes. The pipeline must stall on st_ready=0.
  - No same-cycle bypass of full: st_ready=0 when full even if mem_wr_ack=1 that cycle.
- Drain: mem_wr_req = !empty. mem_wr_addr and mem_wr_data come combinationally from the head entry.
  - Outputs are held stable until mem_wr_ack.
  - On mem_wr_req && mem_wr_ack: the head valid bit clears and head increments modulo DEPTH.
  - mem_wr_ack while empty is ignored.
- Count update:
  - +1 on accept only.
  - -1 on ack only.
  - Unchanged when accept and ack happen in the same cycle; this case is legal at any non-full, non-empty occupancy.
- Load forwarding is purely combinational, with zero-cycle latency. A word match means addr[ADDR_W-1:2] equal. Priority order:
  1. Same-cycle accepted store (st_valid && st_ready) whose word matches ld_addr: ld_hit=1, ld_data=st_data.
  2. Otherwise the youngest valid entry, searched from tail-1 backwards to head with wrap-around, whose word matches: ld_hit=1, ld_data=that entry's data.
  3. Otherwise ld_hit=0, ld_data=0.
- ld_valid=0 forces ld_hit=0 and ld_data=0.
- The head entry being acked in the current cycle is still visible to a load in that cycle.
- A rejected store (full) is never forwarded.
- Pointer wrap: tail==head is disambiguated by count (0 = empty, DEPTH = full).
- Byte lanes are not supported: every entry is a full word. The low two address bits are carried to memory but ignored for matching.

Test Plan:
- Reset, then idle: check empty=1, count=0, mem_wr_req=0, st_ready=1, ld_valid=1 with ld_addr=0x10 -> ld_hit=0.
- Two stores, memory stalled, then load:
  - Stimulus: store 0x100/0xAAAA0001, then store 0x100/0xBBBB0002, mem_wr_ack=0; then load 0x102.
  - Response: ld_hit=1, ld_data=0xBBBB0002 (youngest wins); count=2; mem_wr_addr=0x100, mem_wr_data=0xAAAA0001.
- Fill and back-pressure:
  - Stimulus: 4 stores to 0x0/0x4/0x8/0xC, then a 5th store 0x20/0x55 with ack=0.
  - Response: full=1, st_ready=0, 5th store dropped, load 0x20 -> ld_hit=0. Then ack 4 cycles -> writes 0x0,0x4,0x8,0xC emitted in order, empty=1.
- Same-cycle bypass: count=1 holding 0x40/0x11; same cycle st_valid 0x40/0x22 and ld_valid 0x40 -> ld_hit=1, ld_data=0x22; count=2 next cycle.
- Simultaneous enqueue and drain with wrap:
  - Stimulus: keep count=2 while storing and acking every cycle for 10 cycles, addresses 0x200+4*i.
  - Response: count stays 2, memory receives addresses strictly in order, pointers wrap without loss.
- Async reset mid-operation: count=3, assert rst_n=0 between clock edges -> outputs go to reset values immediately; after release, load of a previously buffered address -> ld_hit=0.

Source files
------------

// File: rtl/store_buffer.sv
// store_buffer
// Word-granular store buffer that sits between the MEM stage and data
// memory. Committed stores are queued in a small circular array and retired
// to memory in FIFO order through a req/ack handshake. Loads issued by the
// MEM stage are answered combinationally with the youngest pending store to
// the same word, so a load that follows a store does not wait for memory.
//
// Ports:
//   clk, rst_n                 clock (rising edge), async active-low reset
//   st_valid/st_addr/st_data   store commit from MEM; st_ready = !full
//   ld_valid/ld_addr           load lookup from MEM
//   ld_hit/ld_data             forwarded result (ld_data is 0 when no hit)
//   mem_wr_req/addr/data       head entry presented to data memory
//   mem_wr_ack                 memory accepted the head entry this cycle
//   full/empty/count           occupancy status
module store_buffer #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    localparam int CNT_W = $clog2(DEPTH + 1),
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              st_valid,
    input  logic [ADDR_W-1:0] st_addr,
    input  logic [DATA_W-1:0] st_data,
    output logic              st_ready,
    input  logic              ld_valid,
    input  logic [ADDR_W-1:0] ld_addr,
    output logic              ld_hit,
    output logic [DATA_W-1:0] ld_data,
    output logic              mem_wr_req,
    output logic [ADDR_W-1:0] mem_wr_addr,
    output logic [DATA_W-1:0] mem_wr_data,
    input  logic              mem_wr_ack,
    output logic              full,
    output logic              empty,
    output logic [CNT_W-1:0]  count
);

    logic              valid_q [DEPTH];
    logic [ADDR_W-1:0] addr_q  [DEPTH];
    logic [DATA_W-1:0] data_q  [DEPTH];
    logic [PTR_W-1:0]  head_q;
    logic [PTR_W-1:0]  tail_q;
    logic [CNT_W-1:0]  count_q;

    logic              accept;
    logic              drain;
    logic [PTR_W-1:0]  scan_idx;
    logic              unused_ld_low;

    // The low two load address bits never take part in word matching.
    assign unused_ld_low = ^ld_addr[1:0];

    // Pointers alone cannot tell empty from full when they coincide, so the
    // occupancy count decides. There is deliberately no full-and-acked
    // bypass: st_ready stays low for the whole cycle the buffer is full.
    assign full     = (count_q == CNT_W'(DEPTH));
    assign empty    = (count_q == '0);
    assign count    = count_q;
    assign st_ready = !full;
    assign accept   = st_valid && !full;
    assign drain    = mem_wr_ack && !empty;

    // The head entry is shown to memory whenever anything is pending. The
    // address/data are zeroed when idle so the bus is quiet while empty.
    assign mem_wr_req  = !empty;
    assign mem_wr_addr = mem_wr_req ? addr_q[head_q] : '0;
    assign mem_wr_data = mem_wr_req ? data_q[head_q] : '0;

    // Load forwarding. Valid entries are contiguous starting at head, so
    // walking from head towards tail visits them oldest first; letting each
    // later match overwrite the earlier one leaves the youngest match. A
    // store accepted in this very cycle is younger still and wins over all
    // buffered entries. An entry being acked this cycle is still valid here,
    // so it remains visible until the edge that retires it.
    always_comb begin
        ld_hit   = 1'b0;
        ld_data  = '0;
        scan_idx = head_q;
        for (int i = 0; i < DEPTH; i++) begin
            scan_idx = head_q + PTR_W'(i);
            if (valid_q[scan_idx] &&
                addr_q[scan_idx][ADDR_W-1:2] == ld_addr[ADDR_W-1:2]) begin
                ld_hit  = 1'b1;
                ld_data = data_q[scan_idx];
            end
        end
        if (accept && st_addr[ADDR_W-1:2] == ld_addr[ADDR_W-1:2]) begin
            ld_hit  = 1'b1;
            ld_data = st_data;
        end
        if (!ld_valid || !rst_n) begin
            ld_hit  = 1'b0;
            ld_data = '0;
        end
    end

    // Queue state. Enqueue writes at tail, drain retires head; both may
    // happen in one cycle, and since that needs a non-full non-empty buffer
    // they never touch the same slot. Reset throws away anything pending.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                valid_q[i] <= 1'b0;
                addr_q[i]  <= '0;
                data_q[i]  <= '0;
            end
        end else begin
            if (accept) begin
                valid_q[tail_q] <= 1'b1;
                addr_q[tail_q]  <= st_addr;
                data_q[tail_q]  <= st_data;
                tail_q          <= tail_q + PTR_W'(1);
            end
            if (drain) begin
                valid_q[head_q] <= 1'b0;
                head_q          <= head_q + PTR_W'(1);
            end
            case ({accept, drain})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: tb/tb_store_buffer.sv
// tb_store_buffer
// Self-checking bench for store_buffer. A queue of pending {addr, data}
// stores is the reference: stores push at the back, acks pop the front, and
// a load looks for the newest queued store to the same word.
module tb_store_buffer;

    localparam int DEPTH = 4;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
    } entry_t;

    logic        clk;
    logic        rst_n;
    logic        st_valid;
    logic [31:0] st_addr;
    logic [31:0] st_data;
    logic        st_ready;
    logic        ld_valid;
    logic [31:0] ld_addr;
    logic        ld_hit;
    logic [31:0] ld_data;
    logic        mem_wr_req;
    logic [31:0] mem_wr_addr;
    logic [31:0] mem_wr_data;
    logic        mem_wr_ack;
    logic        full;
    logic        empty;
    logic [2:0]  count;

    entry_t mq[$];
    int     n_vec = 0;
    int     n_err = 0;

    store_buffer #(.DEPTH(DEPTH), .ADDR_W(32), .DATA_W(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .st_valid(st_valid), .st_addr(st_addr), .st_data(st_data), .st_ready(st_ready),
        .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_hit(ld_hit), .ld_data(ld_data),
        .mem_wr_req(mem_wr_req), .mem_wr_addr(mem_wr_addr), .mem_wr_data(mem_wr_data),
        .mem_wr_ack(mem_wr_ack), .full(full), .empty(empty), .count(count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Inputs are driven just after the falling edge.
    task automatic drive(input logic sv, input logic [31:0] sa, input logic [31:0] sd,
                         input logic lv, input logic [31:0] la, input logic ack);
        st_valid   = sv;
        st_addr    = sa;
        st_data    = sd;
        ld_valid   = lv;
        ld_addr    = la;
        mem_wr_ack = ack;
    endtask

    // Advance one clock and apply the same transfer to the reference queue.
    task automatic cycle();
        bit acc;
        bit drn;
        acc = st_valid && (mq.size() < DEPTH);
        drn = mem_wr_ack && (mq.size() > 0);
        @(posedge clk);
        if (drn) void'(mq.pop_front());
        if (acc) mq.push_back('{st_addr, st_data});
        @(negedge clk);
    endtask

    // Reference load answer as {hit, data}.
    function automatic logic [32:0] model_load();
        if (!ld_valid) return 33'd0;
        if (st_valid && mq.size() < DEPTH && st_addr[31:2] == ld_addr[31:2])
            return {1'b1, st_data};
        for (int i = mq.size() - 1; i >= 0; i--)
            if (mq[i].addr[31:2] == ld_addr[31:2]) return {1'b1, mq[i].data};
        return 33'd0;
    endfunction

    task automatic test_reset();
        rst_n = 1'b0;
        drive(0, 0, 0, 0, 0, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        mq.delete();
        drive(0, 0, 0, 1, 32'h10, 0);
        #1;
        n_vec++; if (empty !== 1'b1) begin n_err++; $display("[TB] FAIL reset_empty got %0b want 1", empty); end
        n_vec++; if (count !== 3'd0) begin n_err++; $display("[TB] FAIL reset_count got %0d want 0", count); end
        n_vec++; if (mem_wr_req !== 1'b0) begin n_err++; $display("[TB] FAIL reset_req got %0b want 0", mem_wr_req); end
        n_vec++; if (st_ready !== 1'b1) begin n_err++; $display("[TB] FAIL reset_ready got %0b want 1", st_ready); end
        n_vec++; if (full !== 1'b0) begin n_err++; $display("[TB] FAIL reset_full got %0b want 0", full); end
        n_vec++; if (ld_hit !== 1'b0) begin n_err++; $display("[TB] FAIL reset_ldhit got %0b want 0", ld_hit); end
        cycle();
    endtask

    task automatic test_two_stores();
        drive(1, 32'h100, 32'hAAAA0001, 0, 0, 0); cycle();
        drive(1, 32'h100, 32'hBBBB0002, 0, 0, 0); cycle();
        drive(0, 0, 0, 1, 32'h102, 0);
        #1;
        n_vec++; if (ld_hit !== 1'b1) begin n_err++; $display("[TB] FAIL two_hit got %0b want 1", ld_hit); end
        n_vec++; if (ld_data !== 32'hBBBB0002) begin n_err++; $display("[TB] FAIL two_data got %h want BBBB0002", ld_data); end
        n_vec++; if (count !== 3'd2) begin n_err++; $display("[TB] FAIL two_count got %0d want 2", count); end
        n_vec++; if (mem_wr_addr !== 32'h100) begin n_err++; $display("[TB] FAIL two_waddr got %h want 100", mem_wr_addr); end
        n_vec++; if (mem_wr_data !== 32'hAAAA0001) begin n_err++; $display("[TB] FAIL two_wdata got %h want AAAA0001", mem_wr_data); end
        // Acked head is still forwardable in its retiring cycle.
        drive(0, 0, 0, 1, 32'h100, 1);
        #1;
        n_vec++; if (ld_data !== 32'hBBBB0002) begin n_err++; $display("[TB] FAIL two_ackfwd got %h want BBBB0002", ld_data); end
        cycle();
        #1;
        n_vec++; if (mem_wr_data !== 32'hBBBB0002) begin n_err++; $display("[TB] FAIL two_head2 got %h want BBBB0002", mem_wr_data); end
        cycle();
        drive(0, 0, 0, 0, 0, 0);
        #1;
        n_vec++; if (empty !== 1'b1) begin n_err++; $display("[TB] FAIL two_drained got %0b want 1", empty); end
    endtask

    task automatic test_fill();
        for (int i = 0; i < 4; i++) begin
            drive(1, 32'(4 * i), 32'hC0DE0000 + 32'(i), 0, 0, 0);
            cycle();
        end
        drive(1, 32'h20, 32'h55, 1, 32'h20, 0);
        #1;
        n_vec++; if (full !== 1'b1) begin n_err++; $display("[TB] FAIL fill_full got %0b want 1", full); end
        n_vec++; if (st_ready !== 1'b0) begin n_err++; $display("[TB] FAIL fill_ready got %0b want 0", st_ready); end
        n_vec++; if (ld_hit !== 1'b0) begin n_err++; $display("[TB] FAIL fill_rejfwd got %0b want 0", ld_hit); end
        cycle();
        drive(0, 0, 0, 1, 32'h20, 0);
        #1;
        n_vec++; if (count !== 3'd4) begin n_err++; $display("[TB] FAIL fill_dropped got %0d want 4", count); end
        n_vec++; if (ld_hit !== 1'b0) begin n_err++; $display("[TB] FAIL fill_nohit got %0b want 0", ld_hit); end
        // Ack while full does not open st_ready in the same cycle.
        drive(1, 32'h24, 32'h66, 0, 0, 1);
        #1;
        n_vec++; if (st_ready !== 1'b0) begin n_err++; $display("[TB] FAIL fill_nobypass got %0b want 0", st_ready); end
        for (int i = 0; i < 4; i++) begin
            drive(0, 0, 0, 0, 0, 1);
            #1;
            n_vec++; if (mem_wr_addr !== 32'(4 * i)) begin n_err++; $display("[TB] FAIL fill_order%0d got %h want %h", i, mem_wr_addr, 4 * i); end
            cycle();
        end
        drive(0, 0, 0, 0, 0, 1);
        #1;
        n_vec++; if (empty !== 1'b1) begin n_err++; $display("[TB] FAIL fill_empty got %0b want 1", empty); end
        cycle();
        n_vec++; if (count !== 3'd0) begin n_err++; $display("[TB] FAIL fill_emptyack got %0d want 0", count); end
    endtask

    task automatic test_bypass();
        drive(1, 32'h40, 32'h11, 0, 0, 0); cycle();
        drive(1, 32'h40, 32'h22, 1, 32'h40, 0);
        #1;
        n_vec++; if (ld_hit !== 1'b1) begin n_err++; $display("[TB] FAIL byp_hit got %0b want 1", ld_hit); end
        n_vec++; if (ld_data !== 32'h22) begin n_err++; $display("[TB] FAIL byp_data got %h want 22", ld_data); end
        cycle();
        drive(0, 0, 0, 0, 32'h40, 0);
        #1;
        n_vec++; if (count !== 3'd2) begin n_err++; $display("[TB] FAIL byp_count got %0d want 2", count); end
        n_vec++; if (ld_hit !== 1'b0) begin n_err++; $display("[TB] FAIL byp_ldvalid0 got %0b want 0", ld_hit); end
        drive(0, 0, 0, 0, 0, 1); cycle(); cycle();
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 2; i++) begin
            drive(1, 32'h200 + 32'(4 * i), 32'h9000 + 32'(i), 0, 0, 0);
            cycle();
        end
        for (int i = 2; i < 12; i++) begin
            drive(1, 32'h200 + 32'(4 * i), 32'h9000 + 32'(i), 0, 0, 1);
            #1;
            n_vec++; if (count !== 3'd2) begin n_err++; $display("[TB] FAIL b2b_count%0d got %0d want 2", i, count); end
            n_vec++; if (mem_wr_addr !== 32'h200 + 32'(4 * (i - 2))) begin n_err++; $display("[TB] FAIL b2b_addr%0d got %h want %h", i, mem_wr_addr, 32'h200 + 4 * (i - 2)); end
            cycle();
        end
        for (int i = 10; i < 12; i++) begin
            drive(0, 0, 0, 0, 0, 1);
            #1;
            n_vec++; if (mem_wr_data !== 32'h9000 + 32'(i)) begin n_err++; $display("[TB] FAIL b2b_tail%0d got %h want %h", i, mem_wr_data, 32'h9000 + i); end
            cycle();
        end
    endtask

    task automatic test_random();
        logic [32:0] exp_ld;
        for (int n = 0; n < 400; n++) begin
            drive($urandom_range(0, 1), 32'h300 + 32'($urandom_range(0, 7) * 4) + 32'($urandom_range(0, 3)),
                  $urandom(), $urandom_range(0, 1),
                  32'h300 + 32'($urandom_range(0, 7) * 4) + 32'($urandom_range(0, 3)), $urandom_range(0, 2) == 0);
            #1;
            exp_ld = model_load();
            n_vec++; if (count !== 3'(mq.size())) begin n_err++; $display("[TB] FAIL rnd_count got %0d want %0d", count, mq.size()); end
            n_vec++; if (st_ready !== (mq.size() < DEPTH)) begin n_err++; $display("[TB] FAIL rnd_ready got %0b want %0b", st_ready, mq.size() < DEPTH); end
            n_vec++; if ({ld_hit, ld_data} !== exp_ld) begin n_err++; $display("[TB] FAIL rnd_load got %0b/%h want %0b/%h", ld_hit, ld_data, exp_ld[32], exp_ld[31:0]); end
            if (mq.size() > 0) begin
                n_vec++; if ({mem_wr_req, mem_wr_addr, mem_wr_data} !== {1'b1, mq[0].addr, mq[0].data}) begin n_err++; $display("[TB] FAIL rnd_head got %0b/%h/%h want 1/%h/%h", mem_wr_req, mem_wr_addr, mem_wr_data, mq[0].addr, mq[0].data); end
            end else begin
                n_vec++; if (mem_wr_req !== 1'b0) begin n_err++; $display("[TB] FAIL rnd_idle got %0b want 0", mem_wr_req); end
            end
            cycle();
        end
        drive(0, 0, 0, 0, 0, 1);
        repeat (DEPTH) cycle();
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 3; i++) begin
            drive(1, 32'h500 + 32'(4 * i), 32'h7700 + 32'(i), 0, 0, 0);
            cycle();
        end
        drive(0, 0, 0, 1, 32'h504, 0);
        #1;
        n_vec++; if (ld_hit !== 1'b1) begin n_err++; $display("[TB] FAIL rstm_prehit got %0b want 1", ld_hit); end
        #1;
        rst_n = 1'b0;
        #1;
        n_vec++; if (count !== 3'd0) begin n_err++; $display("[TB] FAIL rstm_count got %0d want 0", count); end
        n_vec++; if (empty !== 1'b1) begin n_err++; $display("[TB] FAIL rstm_empty got %0b want 1", empty); end
        n_vec++; if (mem_wr_req !== 1'b0) begin n_err++; $display("[TB] FAIL rstm_req got %0b want 0", mem_wr_req); end
        n_vec++; if (mem_wr_addr !== 32'h0) begin n_err++; $display("[TB] FAIL rstm_waddr got %h want 0", mem_wr_addr); end
        n_vec++; if (ld_hit !== 1'b0) begin n_err++; $display("[TB] FAIL rstm_ldhit got %0b want 0", ld_hit); end
        @(negedge clk);
        rst_n = 1'b1;
        mq.delete();
        #1;
        n_vec++; if (ld_hit !== 1'b0) begin n_err++; $display("[TB] FAIL rstm_post got %0b want 0", ld_hit); end
        n_vec++; if (st_ready !== 1'b1) begin n_err++; $display("[TB] FAIL rstm_ready got %0b want 1", st_ready); end
    endtask

    initial begin
        $display("[TB] store_buffer bench start");
        test_reset();
        test_two_stores();
        test_fill();
        test_bypass();
        test_back_to_back();
        test_random();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
